// File: rtl/ov5640_pwr_mon.sv
// Sensor-side monitor for the OV5640 PWDN/RESETB pins: enforces power-up timing and gates SCCB access.
// Optional power-up/error event counters are enabled with `define OV5640_PWR_MON_CNT_EN.
module ov5640_pwr_mon #(
    parameter int unsigned CLK_FREQ_MHZ = 100,
    parameter int unsigned T_PWDN_US    = 1000,
    parameter int unsigned T_SETTLE_US  = 20000
) (
    input  logic        s_axil_aclk,
    input  logic        s_axil_arst,
    input  logic        cam_pwdn,
    input  logic        cam_rst_n,
    input  logic        err_clr,
    output logic        sccb_ready,
    output logic [2:0]  mon_state,
    output logic        err_order,
    output logic        err_early,
    output logic [15:0] pwrup_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned EVT_W = 16;
    localparam logic [CNT_W-1:0] PWDN_CYC    = CNT_W'(CLK_FREQ_MHZ * T_PWDN_US);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLK_FREQ_MHZ * T_SETTLE_US - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWR_UP = 3'd1,
        S_SETTLE = 3'd2,
        S_READY  = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               err_order_q, err_order_d;
    logic               err_early_q, err_early_d;

    always_ff @(posedge s_axil_aclk) begin
        if (s_axil_arst) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            err_order_q <= 1'b0;
            err_early_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            err_order_q <= err_order_d;
            err_early_q <= err_early_d;
        end
    end

    // Pin sequencing rules; power-down always wins over reset activity.
    always_comb begin
        state_d     = state_q;
        err_order_d = err_order_q;
        err_early_d = err_early_q;
        case (state_q)
            S_OFF: begin
                if (!cam_pwdn) begin
                    if (cam_rst_n) begin
                        state_d     = S_ERR;
                        err_order_d = 1'b1;
                    end else begin
                        state_d = S_PWR_UP;
                    end
                end
            end
            S_PWR_UP: begin
                if (cam_pwdn) begin
                    state_d = S_OFF;
                end else if (cam_rst_n) begin
                    if (cnt_q >= PWDN_CYC) begin
                        state_d = S_SETTLE;
                    end else begin
                        state_d     = S_ERR;
                        err_early_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (cam_pwdn) begin
                    state_d = S_OFF;
                end else if (!cam_rst_n) begin
                    state_d = S_PWR_UP;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (cam_pwdn) begin
                    state_d = S_OFF;
                end else if (!cam_rst_n) begin
                    state_d = S_PWR_UP;
                end
            end
            S_ERR: begin
                if (err_clr && cam_pwdn) begin
                    state_d     = S_OFF;
                    err_order_d = 1'b0;
                    err_early_d = 1'b0;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Dwell counter restarts on any transition and saturates instead of wrapping.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        ready_d = (state_d == S_READY);
    end

`ifdef OV5640_PWR_MON_CNT_EN
    logic [EVT_W-1:0] pwrup_cnt_q;
    logic [EVT_W-1:0] err_cnt_q;

    always_ff @(posedge s_axil_aclk) begin
        if (s_axil_arst) begin
            pwrup_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (state_d == S_READY && state_q != S_READY && pwrup_cnt_q != '1) begin
                pwrup_cnt_q <= pwrup_cnt_q + EVT_W'(1);
            end
            if (state_d == S_ERR && state_q != S_ERR && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + EVT_W'(1);
            end
        end
    end

    assign pwrup_cnt = pwrup_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign pwrup_cnt = EVT_W'(0);
    assign err_cnt   = EVT_W'(0);
`endif

    assign sccb_ready = ready_q;
    assign mon_state  = state_q;
    assign err_order  = err_order_q;
    assign err_early  = err_early_q;

endmodule

// File: tb/tb_ov5640_pwr_mon.sv
// Scoreboard bench for ov5640_pwr_mon: directed pin sequences, expected outputs queued per cycle.
module tb_ov5640_pwr_mon;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_PWR_UP = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_READY  = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam int unsigned TIMEOUT_CYC = 5000;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cam_pwdn = 1'b1;
    logic        cam_rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        sccb_ready;
    logic [2:0]  mon_state;
    logic        err_order;
    logic        err_early;
    logic [15:0] pwrup_cnt;
    logic [15:0] err_cnt;

    ov5640_pwr_mon #(
        .CLK_FREQ_MHZ(1),
        .T_PWDN_US   (10),
        .T_SETTLE_US (20)
    ) dut (
        .s_axil_aclk(clk),
        .s_axil_arst(arst),
        .cam_pwdn   (cam_pwdn),
        .cam_rst_n  (cam_rst_n),
        .err_clr    (err_clr),
        .sccb_ready (sccb_ready),
        .mon_state  (mon_state),
        .err_order  (err_order),
        .err_early  (err_early),
        .pwrup_cnt  (pwrup_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  st;
        logic        rdy;
        logic        eo;
        logic        ee;
        logic [15:0] pc;
        logic [15:0] ec;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          pc_m = 0;
    int          ec_m = 0;
    bit          done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose sample cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (mon_state !== mon_e.st || sccb_ready !== mon_e.rdy || err_order !== mon_e.eo ||
                err_early !== mon_e.ee || pwrup_cnt !== mon_e.pc || err_cnt !== mon_e.ec) begin
                n_bad++;
                $display("FAIL %s: got st=%0d rdy=%0b eo=%0b ee=%0b pc=%0d ec=%0d, want st=%0d rdy=%0b eo=%0b ee=%0b pc=%0d ec=%0d",
                         mon_e.name, mon_state, sccb_ready, err_order, err_early, pwrup_cnt, err_cnt,
                         mon_e.st, mon_e.rdy, mon_e.eo, mon_e.ee, mon_e.pc, mon_e.ec);
            end
        end
    end

    // Watchdog: the directed sequence must finish within the cycle budget.
    initial begin
        repeat (TIMEOUT_CYC) @(posedge clk);
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: sequence did not finish within %0d cycles", TIMEOUT_CYC);
            $finish;
        end
    end

    function automatic logic [15:0] cexp(input int v);
`ifdef OV5640_PWR_MON_CNT_EN
        return 16'(v);
`else
        return 16'd0;
`endif
    endfunction

    // Apply one cycle of inputs (sampled by the next rising edge).
    task automatic drive(input logic p, input logic r, input logic c, input logic a);
        @(negedge clk);
        cam_pwdn  = p;
        cam_rst_n = r;
        err_clr   = c;
        arst      = a;
    endtask

    task automatic hold(input logic p, input logic r, input int n);
        for (int i = 0; i < n; i++) drive(p, r, 1'b0, 1'b0);
    endtask

    // Expected outputs after the edge that samples the most recently driven inputs.
    task automatic expect_out(input logic [2:0] st, input logic rdy, input logic eo,
                              input logic ee, input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.st   = st;
        e.rdy  = rdy;
        e.eo   = eo;
        e.ee   = ee;
        e.pc   = cexp(pc_m);
        e.ec   = cexp(ec_m);
        e.name = name;
        sb.push_back(e);
    endtask

    // Immediate check of the all-zero reset state.
    task automatic check_reset_state(input string name);
        @(negedge clk);
        n_vec++;
        if (mon_state !== S_OFF || sccb_ready !== 1'b0 || err_order !== 1'b0 ||
            err_early !== 1'b0 || pwrup_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL %s: got st=%0d rdy=%0b eo=%0b ee=%0b pc=%0d ec=%0d, want all zero",
                     name, mon_state, sccb_ready, err_order, err_early, pwrup_cnt, err_cnt);
        end
    endtask

    initial begin
        // Reset
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out(S_OFF, 0, 0, 0, "reset");
        check_reset_state("reset_state");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "idle_off");

        // Nominal: rst_n held low 12 cycles in PWR_UP, then released
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(S_PWR_UP, 0, 0, 0, "nom_pwr_up");
        hold(1'b0, 1'b0, 11);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "nom_settle");
        hold(1'b0, 1'b1, 18);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "nom_settle_19");
        pc_m = 1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_READY, 1, 0, 0, "nom_ready_20");
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_READY, 1, 0, 0, "nom_ready_hold");

        // Power-down from READY together with reset: pwdn wins
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "ready_pwdn");

        // PWDN boundary: cnt = 10 is accepted
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "pwdn_cnt10");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "settle_pwdn");

        // PWDN boundary: cnt = 9 is early
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 1'b0, 9);
        ec_m = 1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_ERR, 0, 0, 1, "pwdn_cnt9_err");
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out(S_ERR, 0, 0, 1, "early_clr_no_pwdn");
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "early_clr");

        // Order violation: leave power-down with reset already released
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ec_m = 2;
        expect_out(S_ERR, 0, 1, 0, "order_err");
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        expect_out(S_ERR, 0, 1, 0, "order_clr_no_pwdn");
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "order_clr");
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "clr_outside_err");

        // Re-reset at settle cycle 15, then full 10 + 20 sequence again
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 1'b0, 11);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "rr_settle");
        hold(1'b0, 1'b1, 15);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(S_PWR_UP, 0, 0, 0, "rr_back_pwr_up");
        hold(1'b0, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "rr_settle2");
        hold(1'b0, 1'b1, 18);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "rr_settle2_19");
        pc_m = 2;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_READY, 1, 0, 0, "rr_ready");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(S_PWR_UP, 0, 0, 0, "ready_rerst");

        // Synchronous reset in the middle of SETTLE
        hold(1'b0, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out(S_SETTLE, 0, 0, 0, "mid_settle");
        hold(1'b0, 1'b1, 5);
        pc_m = 0;
        ec_m = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        expect_out(S_OFF, 0, 0, 0, "mid_reset");
        check_reset_state("mid_reset_state");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(S_OFF, 0, 0, 0, "post_reset");

        repeat (3) @(negedge clk);
        done = 1'b1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL expired: %0d expectations never sampled", sb.size());
        end
        if (n_vec == 0) begin
            n_bad++;
            $display("FAIL no vectors applied");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule

// File: doc/ov5640_pwr_mon.md
Name: ov5640_pwr_mon

Overview:
- Sensor-side monitor for the OV5640 power-down/reset pins; the receiving end of the camera reset sequencer.
- Watches `cam_pwdn` and `cam_rst_n` exactly as the sensor sees them and enforces the sensor's power-up timing rules.
- Reports when the SCCB configuration master may start access, and flags sequencing violations.
- Sits in the camera shell between the reset sequencer and the SCCB master.

Parameters:
- CLK_FREQ_MHZ, 100, `s_axil_aclk` frequency in MHz.
- T_PWDN_US, 1000, minimum time `cam_pwdn` low with `cam_rst_n` still low before reset release.
- T_SETTLE_US, 20000, time after reset release before SCCB access is allowed.
- Derived localparams: PWDN_CYC = CLK_FREQ_MHZ*T_PWDN_US; SETTLE_CYC = CLK_FREQ_MHZ*T_SETTLE_US. Both must fit in 32 bits.

Ports:
- s_axil_aclk  in  1  clock.
- s_axil_arst  in  1  synchronous, active-high reset.
- cam_pwdn  in  1  sensor power-down pin, 1 = powered down.
- cam_rst_n  in  1  sensor reset pin, active low.
- err_clr  in  1  single-cycle pulse; clears sticky errors.
- sccb_ready  out  1  1 = sensor settled, SCCB access allowed.
- mon_state  out  3  current FSM state encoding.
- err_order  out  1  sticky: reset released while/before leaving power-down.
- err_early  out  1  sticky: reset released before PWDN_CYC elapsed.
- pwrup_cnt  out  16  successful power-ups (optional feature).
- err_cnt  out  16  error events (optional feature).

Behaviour:
- All outputs registered; all inputs sampled on the rising edge of `s_axil_aclk`.
- Reset (`s_axil_arst`=1 at an edge):
  - state = S_OFF, cnt = 0, `sccb_ready` = 0, `err_order` = 0, `err_early` = 0, counters = 0.
  - Reset mid-sequence aborts immediately to these values.
- States and encoding: S_OFF=0, S_PWR_UP=1, S_SETTLE=2, S_READY=3, S_ERR=4.
- cnt: 32-bit, cleared on every state transition, incremented every cycle the state is held.
- S_OFF:
  - Leave only when `cam_pwdn`=0.
  - If `cam_rst_n`=1 in that same cycle -> S_ERR, set `err_order`.
  - Otherwise -> S_PWR_UP.
- S_PWR_UP (evaluated in priority order):
  - `cam_pwdn`=1 -> S_OFF.
  - `cam_rst_n`=1 with cnt >= PWDN_CYC -> S_SETTLE.
  - `cam_rst_n`=1 with cnt < PWDN_CYC -> S_ERR, set `err_early`.
- S_SETTLE (evaluated in priority order):
  - `cam_pwdn`=1 -> S_OFF.
  - `cam_rst_n`=0 -> S_PWR_UP; re-reset is legal and the count restarts.
  - cnt == SETTLE_CYC-1 -> S_READY.
  - `sccb_ready` therefore rises SETTLE_CYC cycles after the first cycle in which `cam_rst_n`=1 is sampled.
- S_READY:
  - `sccb_ready`=1.
  - `cam_pwdn`=1 -> S_OFF.
  - `cam_rst_n`=0 -> S_PWR_UP.
  - `sccb_ready` drops in the same registered update as the exit transition.
- S_ERR:
  - `sccb_ready`=0.
  - Leave to S_OFF only when `err_clr`=1 and `cam_pwdn`=1 in the same cycle.
  - Error flags clear on that same edge.
  - `err_clr` outside S_ERR, or with `cam_pwdn`=0, has no effect.
- Simultaneous events:
  - `cam_pwdn` assertion has priority over every other event.
  - Reset (`s_axil_arst`) has priority over everything.
- cnt saturates at 2^32-1; it never wraps.

Optional Feature:
- Macro: OV5640_PWR_MON_CNT_EN.
- Defined:
  - `pwrup_cnt` increments on each entry to S_READY.
  - `err_cnt` increments on each entry to S_ERR.
  - Both 16-bit, saturating at 0xFFFF, cleared only by `s_axil_arst`.
- Undefined:
  - Ports remain present, tied to 0, no counter logic.

Test Plan:
All scenarios use CLK_FREQ_MHZ=1, T_PWDN_US=10, T_SETTLE_US=20, giving PWDN_CYC=10 and SETTLE_CYC=20.
- Nominal:
  - Stimulus: `cam_pwdn` 1->0, hold `cam_rst_n`=0 for 12 cycles, release.
  - Expected: `sccb_ready`=1 exactly 20 cycles after the `cam_rst_n` rise is sampled; no errors; `pwrup_cnt`=1 (macro on).
- PWDN boundary:
  - Stimulus: release `cam_rst_n` with cnt=10.
  - Expected: S_SETTLE.
  - Stimulus: repeat with cnt=9.
  - Expected: `err_early`=1, `mon_state`=4, `sccb_ready` stays 0.
- Order violation:
  - Stimulus: `cam_pwdn` 1->0 while `cam_rst_n`=1.
  - Expected: `err_order`=1 next cycle, S_ERR.
  - Stimulus: `err_clr` with `cam_pwdn`=0.
  - Expected: no change.
  - Stimulus: `err_clr` with `cam_pwdn`=1.
  - Expected: S_OFF, flags 0.
- Re-reset during settle:
  - Stimulus: drop `cam_rst_n` at settle cycle 15.
  - Expected: S_PWR_UP, cnt=0; the full 10 + 20 cycle sequence is required again before `sccb_ready`.
- Power-down from READY:
  - Stimulus: assert `cam_pwdn`=1 together with `cam_rst_n`=0.
  - Expected: S_OFF (pwdn priority), `sccb_ready`=0 next cycle.
- Mid-sequence reset:
  - Stimulus: `s_axil_arst` pulse in S_SETTLE.
  - Expected: all outputs 0, `mon_state`=0, counters 0.
